// File: rtl/ddr3_lanectrl_pkg.sv
// Shared types and elaboration helpers for the DDR3 lane-control pause sequencer.
package ddr3_lanectrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_MOVE,
        ST_POST,
        ST_DONE
    } state_t;

    function automatic int cnt_width(input int cnt_w, input int pre, input int post);
        int m;
        int c;
        m = (pre > post) ? pre : post;
        c = $clog2(m + 1);
        return (cnt_w > c) ? cnt_w : c;
    endfunction

    function automatic bit cycles_legal(input int pre, input int post);
        return (pre >= 1) && (post >= 1);
    endfunction

endpackage

// File: rtl/ddr3_lanectrl_pause_seq.sv
// Per-lane sequencer: opens an HS IO clock pause window, issues delay-line
// move strobes inside it, then closes the window and acknowledges.
module ddr3_lanectrl_pause_seq
    import ddr3_lanectrl_pkg::*;
#(
    parameter int PRE_CYCLES  = 2,
    parameter int POST_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ,
    input  logic             DIR,
    input  logic [CNT_W-1:0] MOVE_CNT,
    output logic             BUSY,
    output logic             ACK,
    output logic             HS_IO_CLK_PAUSE,
    output logic             DELAY_MOVE,
    output logic             DELAY_DIR
);

    localparam int W = cnt_width(CNT_W, PRE_CYCLES, POST_CYCLES);
    localparam logic [W-1:0] PRE_LD  = W'(PRE_CYCLES - 1);
    localparam logic [W-1:0] POST_LD = W'(POST_CYCLES - 1);

    if (!cycles_legal(PRE_CYCLES, POST_CYCLES)) begin : g_bad_params
        $error("PRE_CYCLES and POST_CYCLES must both be >= 1");
    end

    state_t           state;
    logic [W-1:0]     cnt;
    logic [CNT_W-1:0] count_q;

    // One down-counter serves PRE, MOVE and POST; outputs are set on the
    // transition into each state so they stay pure flops.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            count_q         <= '0;
            BUSY            <= 1'b0;
            ACK             <= 1'b0;
            HS_IO_CLK_PAUSE <= 1'b0;
            DELAY_MOVE      <= 1'b0;
            DELAY_DIR       <= 1'b0;
        end else begin
            ACK <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (REQ) begin
                        state           <= ST_PRE;
                        cnt             <= PRE_LD;
                        count_q         <= MOVE_CNT;
                        DELAY_DIR       <= DIR;
                        BUSY            <= 1'b1;
                        HS_IO_CLK_PAUSE <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (cnt == '0) begin
                        if (count_q != '0) begin
                            state      <= ST_MOVE;
                            cnt        <= W'(count_q) - W'(1);
                            DELAY_MOVE <= 1'b1;
                        end else begin
                            state <= ST_POST;
                            cnt   <= POST_LD;
                        end
                    end else begin
                        cnt <= cnt - W'(1);
                    end
                end
                ST_MOVE: begin
                    if (cnt == '0) begin
                        state      <= ST_POST;
                        cnt        <= POST_LD;
                        DELAY_MOVE <= 1'b0;
                    end else begin
                        cnt <= cnt - W'(1);
                    end
                end
                ST_POST: begin
                    if (cnt == '0) begin
                        state           <= ST_DONE;
                        HS_IO_CLK_PAUSE <= 1'b0;
                        ACK             <= 1'b1;
                    end else begin
                        cnt <= cnt - W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_lanectrl_pause_seq.sv
// Directed bench for the lane-control pause sequencer, default and
// minimum PRE/POST configurations.
module tb_ddr3_lanectrl_pause_seq;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       dir;
    logic [3:0] mc;
    logic       busy;
    logic       ack;
    logic       pause;
    logic       move;
    logic       ddir;

    logic       req2;
    logic       dir2;
    logic [3:0] mc2;
    logic       busy2;
    logic       ack2;
    logic       pause2;
    logic       move2;
    logic       ddir2;

    int         checks;
    int         errors;
    logic [4:0] got;
    logic [4:0] exp;

    ddr3_lanectrl_pause_seq #(
        .PRE_CYCLES (2),
        .POST_CYCLES(2),
        .CNT_W      (4)
    ) dut (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .REQ            (req),
        .DIR            (dir),
        .MOVE_CNT       (mc),
        .BUSY           (busy),
        .ACK            (ack),
        .HS_IO_CLK_PAUSE(pause),
        .DELAY_MOVE     (move),
        .DELAY_DIR      (ddir)
    );

    ddr3_lanectrl_pause_seq #(
        .PRE_CYCLES (1),
        .POST_CYCLES(1),
        .CNT_W      (4)
    ) dut_min (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .REQ            (req2),
        .DIR            (dir2),
        .MOVE_CNT       (mc2),
        .BUSY           (busy2),
        .ACK            (ack2),
        .HS_IO_CLK_PAUSE(pause2),
        .DELAY_MOVE     (move2),
        .DELAY_DIR      (ddir2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // vector order: {BUSY, ACK, PAUSE, MOVE, DIR}
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        got = {busy, ack, pause, move, ddir};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got %b expected %b", got, 5'b0);
        end
        got = {busy2, ack2, pause2, move2, ddir2};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_state_min got %b expected %b", got, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            got = {busy, ack, pause, move, ddir};
            checks++;
            if (got !== 5'b0) begin
                errors++;
                $display("FAIL idle cycle %0d got %b expected %b", k, got, 5'b0);
            end
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        req = 1'b1;
        dir = 1'b1;
        mc  = 4'd3;
        @(negedge clk);
        req = 1'b0;
        dir = 1'b0;
        mc  = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            exp = {k <= 8, k == 8, k <= 7, (k >= 3) && (k <= 5), 1'b1};
            got = {busy, ack, pause, move, ddir};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic cycle %0d got %b expected %b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_moves();
        req = 1'b1;
        dir = 1'b0;
        mc  = 4'd0;
        @(negedge clk);
        req = 1'b0;
        dir = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            exp = {k <= 5, k == 5, k <= 4, 1'b0, 1'b0};
            got = {busy, ack, pause, move, ddir};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero_moves cycle %0d got %b expected %b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic d;
        req = 1'b1;
        dir = 1'b1;
        mc  = 4'd15;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            d = (s == 0);
            for (int k = 1; k <= 21; k++) begin
                exp = {k <= 20, k == 20, k <= 19, (k >= 3) && (k <= 17), d};
                got = {busy, ack, pause, move, ddir};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b seq %0d cycle %0d got %b expected %b",
                             s, k, got, exp);
                end
                if (s == 0 && k >= 3 && k <= 10) begin
                    req = k[0];
                    dir = k[0];
                    mc  = 4'd7;
                end
                if (s == 0 && k == 11) begin
                    req = 1'b1;
                    dir = 1'b0;
                    mc  = 4'd15;
                end
                if (s == 1 && k == 20) req = 1'b0;
                @(negedge clk);
            end
        end
        got = {busy, ack, pause, move, ddir};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL b2b no_third got %b expected %b", got, 5'b0);
        end
    endtask

    task automatic test_reset_mid();
        req = 1'b1;
        dir = 1'b1;
        mc  = 4'd5;
        @(negedge clk);
        req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp = {1'b1, 1'b0, 1'b1, k >= 3, 1'b1};
            got = {busy, ack, pause, move, ddir};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_pre cycle %0d got %b expected %b", k, got, exp);
            end
            if (k < 4) @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {busy, ack, pause, move, ddir};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL mid_async got %b expected %b", got, 5'b0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = {busy, ack, pause, move, ddir};
            checks++;
            if (got !== 5'b0) begin
                errors++;
                $display("FAIL mid_held %0d got %b expected %b", k, got, 5'b0);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        got = {busy, ack, pause, move, ddir};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL mid_release got %b expected %b", got, 5'b0);
        end
        req = 1'b1;
        dir = 1'b1;
        mc  = 4'd2;
        @(negedge clk);
        req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp = {k <= 7, k == 7, k <= 6, (k >= 3) && (k <= 4), 1'b1};
            got = {busy, ack, pause, move, ddir};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_rerun cycle %0d got %b expected %b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_min_params();
        req2 = 1'b1;
        dir2 = 1'b1;
        mc2  = 4'd1;
        @(negedge clk);
        req2 = 1'b0;
        dir2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp = {k <= 4, k == 4, k <= 3, k == 2, 1'b1};
            got = {busy2, ack2, pause2, move2, ddir2};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL min_params cycle %0d got %b expected %b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 1'b0;
        dir    = 1'b0;
        mc     = 4'd0;
        req2   = 1'b0;
        dir2   = 1'b0;
        mc2    = 4'd0;
        test_reset();
        test_basic();
        test_zero_moves();
        test_back_to_back();
        test_reset_mid();
        test_min_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
